// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared constants and state encoding for the UART TX drain.
// Rev     : 1.0
// ============================================================================
package uart_pkg;

  localparam int DATA_W = 8;

  // PARITY keeps its slot even when parity is compiled out so encodings match.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_drain_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_drain_if
// Brief   : FIFO read-port bundle between the byte FIFO and the TX drain.
// Rev     : 1.0
// ============================================================================
interface uart_tx_drain_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] din;
  logic              empty;
  logic              re;

  // master = FIFO read side, slave = the drain consuming bytes
  modport master (output din, output empty, input re);
  modport slave  (input din, input empty, output re);

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module  : uart_baud_gen
// Brief   : Free-running bit-period counter with a one-cycle terminal tick.
// Rev     : 1.0
// ============================================================================
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  output logic      tick
);

  localparam int                 c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_TERM  = c_CNT_W'(CLKS_PER_BIT - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // clr realigns the count so the first bit after a pop is a full period
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == c_TERM) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign tick = (r_cnt == c_TERM);

endmodule
`default_nettype wire

// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_drain
// Brief   : Pops bytes from the FIFO and serialises them as 8N1 frames
//           (8E1 when UART_TX_PARITY_EN is defined).
// Rev     : 1.0
// ============================================================================
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  uart_tx_drain_if.slave bus,
  input  wire logic      tx_en,
  output logic           tx,
  output logic           busy
);
  import uart_pkg::*;

  localparam int                 c_BIT_W    = $clog2(DATA_W);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_W - 1);

  tx_state_t          r_state;
  tx_state_t          w_state_nxt;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  w_shift_nxt;
  logic [c_BIT_W-1:0] r_bit_cnt;
  logic [c_BIT_W-1:0] w_bit_nxt;
  logic               r_tx;
  logic               w_tx_nxt;
  logic               w_pop;
  logic               w_tick;

  assign w_pop  = (r_state == IDLE) && !bus.empty && tx_en && !rst;
  assign bus.re = w_pop;
  assign tx     = r_tx;
  assign busy   = (r_state != IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_pop),
    .tick (w_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= ^bus.din;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // tx is computed one edge early so the line toggles exactly on state entry
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    w_tx_nxt    = r_tx;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_pop) begin
          w_shift_nxt = bus.din;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          w_bit_nxt   = r_bit_cnt + c_BIT_W'(1);
          w_tx_nxt    = r_shift[1];
          if (r_bit_cnt == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
            w_tx_nxt    = r_parity;
`else
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (w_tick) begin
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
        end
`else
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
`endif
      end
      STOP: begin
        if (w_tick) begin
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_drain
// Brief   : Self-checking bench; predicts line level, busy and pops per cycle
//           from a queue of expected frame levels. Honors UART_TX_PARITY_EN.
// Rev     : 1.0
// ============================================================================
module tb_uart_tx_drain;
  import uart_pkg::*;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;
  localparam int DRAIN_CAP = 9 * (FRAME_CYC + 2) + 20;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic tx_en = 1'b0;
  logic tx;
  logic busy;

  uart_tx_drain_if bus ();

  uart_tx_drain #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (DATA_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .tx_en (tx_en),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int         n_cmp    = 0;
  int         n_err    = 0;
  bit         armed    = 1'b0;
  int         dut_pops = 0;
  int         mdl_pops = 0;
  logic [7:0] fifo[$];
  logic [7:0] mfifo[$];
  logic       line_q[$];

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic refresh();
    bus.empty = (fifo.size() == 0);
    bus.din   = (fifo.size() != 0) ? fifo[0] : 8'hEE;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    mfifo.push_back(b);
    refresh();
  endtask

  // One clock: check at negedge, then advance FIFO and reference at posedge.
  task automatic cycle();
    logic             pred_re;
    logic             re_s;
    logic [7:0]       b;
    logic [NBITS-1:0] fr;
    @(negedge clk);
    pred_re = !rst && tx_en && (line_q.size() == 0) && (mfifo.size() != 0);
    if (armed) begin
      chk_eq("re", {31'd0, bus.re}, {31'd0, pred_re});
      chk_eq("tx", {31'd0, tx}, {31'd0, (line_q.size() != 0) ? line_q[0] : 1'b1});
      chk_eq("busy", {31'd0, busy}, {31'd0, (line_q.size() != 0)});
    end
    re_s = bus.re;
    @(posedge clk);
    if (re_s === 1'b1 && fifo.size() != 0) begin
      void'(fifo.pop_front());
      dut_pops++;
    end
    if (rst) begin
      line_q.delete();
    end else if (line_q.size() != 0) begin
      void'(line_q.pop_front());
    end else if (pred_re) begin
      b = mfifo.pop_front();
      mdl_pops++;
      fr = {1'b1,
`ifdef UART_TX_PARITY_EN
            ^b,
`endif
            b, 1'b0};
      for (int i = 0; i < NBITS; i++) begin
        for (int c = 0; c < CPB; c++) line_q.push_back(fr[i]);
      end
    end
    #1;
    refresh();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fifo.size() != 0 || line_q.size() != 0) && n < DRAIN_CAP) begin
      cycle();
      n++;
    end
    chk_eq("drain_done", {31'd0, (fifo.size() != 0 || line_q.size() != 0)}, 32'd0);
    cycle();
  endtask

  initial begin
    int lim;
    refresh();
    cycle();
    armed = 1'b1;
    cycle();
    cycle();
    rst   = 1'b0;
    tx_en = 1'b1;

    repeat (100) cycle();

    push(8'hA5);
    drain();

    push(8'h00);
    push(8'hFF);
    drain();

    tx_en = 1'b0;
    push(8'h3C);
    repeat (20) cycle();
    tx_en = 1'b1;
    drain();

    // abort a frame part-way through its data bits
    push(8'h55);
    push(8'h5A);
    lim = 0;
    while (line_q.size() != FRAME_CYC - (4 * CPB + 1) && lim < 200) begin
      cycle();
      lim++;
    end
    chk_eq("midframe_reached", {31'd0, (lim < 200)}, 32'd1);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    drain();

    tx_en = 1'b0;
    for (int b = 1; b <= 7; b++) push(8'(b));
    cycle();
    tx_en = 1'b1;
    drain();

    repeat (1500) begin
      if ($urandom_range(0, 3) == 0 && fifo.size() < 8) push(8'($urandom));
      tx_en = ($urandom_range(0, 9) != 0);
      rst   = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst   = 1'b0;
    tx_en = 1'b1;
    drain();

    chk_eq("pop_count", dut_pops, mdl_pops);
    chk_eq("fifo_left", fifo.size(), 32'd0);
    chk_eq("idle_tx", {31'd0, tx}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
